// File: rtl/instr_sequencer.sv
// Step-key driven instruction sequencer: debounced key press latches one instruction,
// then walks register read, ALU execute/wait and write-back; counts retired instructions.
module instr_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ALU_TIMEOUT     = 64,
    parameter int CNT_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_key_n,
    input  logic [3:0]       i_codop,
    input  logic [3:0]       i_add_a,
    input  logic [3:0]       i_add_b_lmm,
    input  logic [3:0]       i_add_c,
    output logic [3:0]       o_rf_raddr_a,
    output logic [3:0]       o_rf_raddr_b,
    output logic             o_rf_ren,
    output logic             o_rf_we,
    output logic [3:0]       o_rf_waddr,
    output logic [2:0]       o_alu_op,
    output logic             o_use_imm,
    output logic [3:0]       o_imm,
    output logic             o_alu_start,
    input  logic             i_alu_done,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TO_W = $clog2(ALU_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_READ, S_EXEC, S_WAIT, S_WB, S_RETIRE, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_timeout;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_lvl;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_step;
    logic [TO_W-1:0]  r_wait_cnt;
    logic [15:0]      r_ir;
    logic             r_rf_ren;
    logic             r_rf_we;
    logic [3:0]       r_rf_waddr;
    logic [2:0]       r_alu_op;
    logic             r_use_imm;
    logic [3:0]       r_imm;
    logic             r_alu_start;
    logic             r_busy;
    logic             r_halted;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_instr_count;

    // Two-flop synchronizer for the asynchronous key; idles at released (1).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce filter: a new level is accepted only after a full run of differing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_lvl <= 1'b1;
            r_db_cnt  <= '0;
            r_step    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (r_sync2 == r_key_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_key_lvl <= r_sync2;
                r_db_cnt  <= '0;
                r_step    <= ~r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; done wins over a timeout expiring in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_step) w_next = S_LATCH;
                else        w_next = S_IDLE;
            end
            S_LATCH: begin
                if (i_codop == 4'h0)      w_next = S_RETIRE;
                else if (i_codop == 4'hF) w_next = S_HALT;
                else                      w_next = S_READ;
            end
            S_READ:   w_next = S_EXEC;
            S_EXEC:   w_next = S_WAIT;
            S_WAIT: begin
                if (i_alu_done) begin
                    w_next = S_WB;
                end else if (r_wait_cnt == TO_W'(ALU_TIMEOUT - 1)) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WB:     w_next = S_RETIRE;
            S_RETIRE: w_next = S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Cycles spent in WAIT, restarted on every entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Instruction register; switches are ignored outside LATCH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir <= 16'h0000;
        end else if (r_state == S_LATCH) begin
            r_ir <= {i_codop, i_add_a, i_add_b_lmm, i_add_c};
        end
    end

    // Registered outputs, decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rf_ren      <= 1'b0;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= 4'h0;
            r_alu_op      <= 3'h0;
            r_use_imm     <= 1'b0;
            r_imm         <= 4'h0;
            r_alu_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_err_timeout <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_rf_ren    <= (w_next == S_READ);
            r_alu_start <= (w_next == S_EXEC);
            r_rf_we     <= (w_next == S_WB);
            r_busy      <= (w_next != S_IDLE);
            r_halted    <= (w_next == S_HALT);
            if (w_next == S_EXEC) begin
                r_alu_op  <= r_ir[14:12];
                r_use_imm <= r_ir[15];
                r_imm     <= r_ir[7:4];
            end
            if (w_next == S_WB) begin
                r_rf_waddr <= r_ir[11:8];
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
            if ((r_state == S_RETIRE) || ((r_state == S_LATCH) && (w_next == S_HALT))) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    // Read addresses come straight from the IR, so they hold until the next LATCH.
    assign o_rf_raddr_a  = r_ir[3:0];
    assign o_rf_raddr_b  = r_ir[7:4];
    assign o_rf_ren      = r_rf_ren;
    assign o_rf_we       = r_rf_we;
    assign o_rf_waddr    = r_rf_waddr;
    assign o_alu_op      = r_alu_op;
    assign o_use_imm     = r_use_imm;
    assign o_imm         = r_imm;
    assign o_alu_start   = r_alu_start;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_err_timeout = r_err_timeout;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: scoreboard of expected read/execute/write-back
// records pushed at stimulus time and checked as the DUT pulses its strobes.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic [3:0] codop = 4'h0;
    logic [3:0] add_a = 4'h0;
    logic [3:0] add_b = 4'h0;
    logic [3:0] add_c = 4'h0;
    logic       alu_done = 1'b0;
    logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr, imm;
    logic       rf_ren, rf_we, use_imm, alu_start, busy, halted, err_timeout;
    logic [2:0] alu_op;
    logic [7:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;
    int ren_cnt = 0;
    int start_cnt = 0;
    int we_cnt = 0;
    int alu_delay = 3;
    bit alu_respond = 1'b1;

    typedef struct {
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] op;
        logic       ui;
        logic [3:0] imm;
        logic [3:0] wa;
    } exp_t;
    exp_t exp_q[$];

    instr_sequencer #(.DEBOUNCE_CYCLES(16), .ALU_TIMEOUT(64), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_n(key_n),
        .i_codop(codop), .i_add_a(add_a), .i_add_b_lmm(add_b), .i_add_c(add_c),
        .o_rf_raddr_a(rf_raddr_a), .o_rf_raddr_b(rf_raddr_b), .o_rf_ren(rf_ren),
        .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_alu_op(alu_op),
        .o_use_imm(use_imm), .o_imm(imm), .o_alu_start(alu_start),
        .i_alu_done(alu_done), .o_busy(busy), .o_halted(halted),
        .o_err_timeout(err_timeout), .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {30'h0, rf_raddr_a, rf_raddr_b, rf_ren, rf_we, rf_waddr, alu_op,
                use_imm, imm, alu_start, busy, halted, err_timeout, instr_count};
    endfunction

    // Behavioural ALU: clears done on start, raises it alu_delay cycles later and holds it.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1) begin
                alu_done = 1'b0;
                if (alu_respond) begin
                    repeat (alu_delay) @(negedge clk);
                    alu_done = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: strobes are checked against the oldest pending record.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rf_ren) begin
                    ren_cnt++;
                    if (exp_q.size() == 0) chk("ren_unexpected", 64'(exp_q.size()), 64'd1);
                    else begin
                        chk("raddr_a", rf_raddr_a, exp_q[0].ra);
                        chk("raddr_b", rf_raddr_b, exp_q[0].rb);
                    end
                end
                if (alu_start) begin
                    start_cnt++;
                    if (exp_q.size() == 0) chk("start_unexpected", 64'(exp_q.size()), 64'd1);
                    else begin
                        chk("alu_op", alu_op, exp_q[0].op);
                        chk("use_imm", use_imm, exp_q[0].ui);
                        chk("imm", imm, exp_q[0].imm);
                    end
                end
                if (rf_we) begin
                    we_cnt++;
                    if (exp_q.size() == 0) chk("we_unexpected", 64'(exp_q.size()), 64'd1);
                    else begin
                        chk("waddr", rf_waddr, exp_q[0].wa);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c);
        exp_t e;
        e.ra = c; e.rb = b; e.op = op[2:0]; e.ui = op[3]; e.imm = b; e.wa = a;
        exp_q.push_back(e);
    endtask

    // Press the key with the given switch settings and follow the instruction to completion.
    task automatic do_instr(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input bit exec,
                            output int lat_busy, output int lat_we);
        int k;
        codop = op; add_a = a; add_b = b; add_c = c;
        if (exec) push_exp(op, a, b, c);
        key_n = 1'b0;
        k = 0;
        while (!busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        lat_busy = busy ? k : -1;
        lat_we = -1;
        k = 0;
        while (busy && !halted && k < 200) begin
            @(negedge clk);
            k++;
            if (rf_we && lat_we < 0) lat_we = k;
        end
        key_n = 1'b1;
        repeat (22) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lb, lw, k, snap_we, snap_ren, snap_start;
        bit early;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", all_outs(), 64'h0);

        // Bouncing key, then a stable press carrying an R-type instruction
        early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_n = ~key_n;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                if (busy) early = 1'b1;
            end
        end
        chk("bounce_no_latch", {63'h0, early}, 64'h0);
        alu_delay = 3;
        do_instr(4'h2, 4'h3, 4'h5, 4'h7, 1'b1, lb, lw);
        chk("press_to_latch", 64'(lb), 64'd19);
        chk("rtype_we_count", 64'(we_cnt), 64'd1);
        chk("rtype_ren_count", 64'(ren_cnt), 64'd1);
        chk("rtype_count", instr_count, 8'd1);
        chk("rtype_idle", busy, 1'b0);

        // Immediate form, ALU answering on the first WAIT cycle
        alu_delay = 1;
        do_instr(4'hA, 4'h1, 4'h9, 4'h6, 1'b1, lb, lw);
        chk("imm_latch_to_we", 64'(lw), 64'd4);
        chk("imm_count", instr_count, 8'd2);
        chk("imm_we_count", 64'(we_cnt), 64'd2);

        // NOP then HALT from a fresh reset
        do_reset();
        do_instr(4'h0, 4'h4, 4'h4, 4'h4, 1'b0, lb, lw);
        chk("nop_count", instr_count, 8'd1);
        chk("nop_no_ren", 64'(ren_cnt), 64'd2);
        do_instr(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, lb, lw);
        chk("halt_count", instr_count, 8'd2);
        chk("halt_flag", halted, 1'b1);
        chk("halt_busy", busy, 1'b1);
        snap_ren = ren_cnt;
        snap_start = start_cnt;
        codop = 4'h2; add_a = 4'h2; add_b = 4'h2; add_c = 4'h2;
        key_n = 1'b0;
        repeat (25) @(negedge clk);
        key_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("halt_no_ren", 64'(ren_cnt), 64'(snap_ren));
        chk("halt_no_start", 64'(start_cnt), 64'(snap_start));
        chk("halt_count_hold", instr_count, 8'd2);

        // ALU never answers
        do_reset();
        alu_respond = 1'b0;
        snap_we = we_cnt;
        do_instr(4'h3, 4'h8, 4'h1, 4'h2, 1'b1, lb, lw);
        chk("to_err", err_timeout, 1'b1);
        chk("to_no_we", 64'(we_cnt), 64'(snap_we));
        chk("to_count", instr_count, 8'd0);
        chk("to_busy", busy, 1'b0);
        chk("to_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();

        // Counter wrap over 256 NOPs; timeout flag stays sticky
        for (int n = 0; n < 255; n++) do_instr(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, lb, lw);
        chk("count_255", instr_count, 8'hFF);
        do_instr(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, lb, lw);
        chk("count_wrap", instr_count, 8'h00);
        chk("err_sticky", err_timeout, 1'b1);

        // Reset asserted while waiting on the ALU
        snap_we = we_cnt;
        push_exp(4'h5, 4'hC, 4'hD, 4'hE);
        codop = 4'h5; add_a = 4'hC; add_b = 4'hD; add_c = 4'hE;
        key_n = 1'b0;
        k = 0;
        while (!alu_start && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_exec", alu_start, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_outputs", all_outs(), 64'h0);
        exp_q.delete();
        key_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_no_we", 64'(we_cnt), 64'(snap_we));
        chk("rst_idle_outputs", all_outs(), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
